ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  Execute stage between the ID/EX and EX/MEM pipeline registers. Consumes decoded operands and
//  controls, resolves data hazards by forwarding from EX/MEM and MEM/WB, and evaluates the ALU.
//  Runs an iterative multiplier for MUL, stalling upstream while it runs. Registers results toward EX/MEM.
// PARAMETERS
//  DW          32  datapath width
//  MUL_CYCLES  32  shift-add iterations per MUL; must be >= 2
// PORTS
//  clk_i             in   1   clock, posedge active
//  rst_n_i           in   1   asynchronous active-low reset
//  CacheStall_i      in   1   global freeze from memory stage
//  WB_i / MEM_i      in   2/2 pass-through controls; WB_i[1] = RegWrite
//  ALU_Src_i         in   1   1: operand B = immd_i
//  ALU_OP_i          in   2   00 add, 01 sub, 10 R-type by funct, 11 or-immediate
//  Reg_Dst_i         in   1   1: destination = Rd, 0: destination = Rt
//  Reg_data1_i/2_i   in   DW  register-file operands
//  immd_i            in   DW  sign-extended immediate; immd_i[5:0] = funct
//  RsAddr_FW_i/Rt    in   5/5 source addresses for forwarding
//  RtAddr_WB_i/Rd    in   5/5 destination candidates
//  EXMEM_RegWrite_i  in   1   / EXMEM_RdAddr_i 5 / EXMEM_ALUout_i DW: forwarding source 1
//  MEMWB_RegWrite_i  in   1   / MEMWB_RdAddr_i 5 / MEMWB_Data_i DW: forwarding source 2
//  WB_o / MEM_o      out  2/2 registered controls to EX/MEM
//  ALUout_o          out  DW  registered result
//  MemWriteData_o    out  DW  registered forwarded Rt value, for stores
//  RegDstAddr_o      out  5   registered destination address
//  stall_o           out  1   combinational; 1 = ID/EX and upstream stages must hold
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counter 0, multiplier regs 0. Takes effect immediately, including mid-MUL.
//  Forwarding, per operand: EX/MEM wins when its RegWrite is set, its RdAddr != 0 and it matches.
//    Otherwise MEM/WB under the same rules. Otherwise the register value. Address 0 is never forwarded.
//  Operand B = ALU_Src_i ? immd_i : forwarded Rt. MemWriteData_o always gets forwarded Rt.
//  Funct codes (ALU_OP=10): 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed),
//    011000 mul (low DW bits). Unknown funct gives 0. All arithmetic wraps modulo 2^DW; no overflow trap.
//  Latency: non-MUL ops register one posedge after inputs are presented.
//  FSM states: IDLE, MUL.
//    IDLE: if not a MUL, outputs register every edge and stall_o = 0.
//    IDLE with MUL decoded: stall_o = 1. Forwarded A and B are latched, cnt = 0, next state MUL.
//      The bubble WB_o = MEM_o = 0 is registered at that edge.
//    MUL: one shift-add step per edge, cnt++. stall_o = 1 while cnt != MUL_CYCLES-1, and WB_o/MEM_o stay 0.
//    MUL at cnt == MUL_CYCLES-1: stall_o = 0. Product, WB, MEM and dest register at that edge; then IDLE.
//    Net effect: upstream is held for MUL_CYCLES cycles, and one valid result is produced.
//  Operands are latched at MUL start, so later forwarding changes do not disturb the product.
//  CacheStall_i = 1: every register holds (outputs, state, cnt, accumulator); stall_o is unaffected.
//    CacheStall_i has priority over any FSM transition.
//  Simultaneous EX/MEM and MEM/WB match: EX/MEM wins.
// STRUCTURE
//  Shared package ex_pkg: ALU_OP and funct localparams, FSM state encoding, DW default.
//  Sub-module seq_mul: start/busy/done handshake, latched operands, cnt, accumulator.
//  Parent holds the forwarding muxes, combinational ALU, output regs and stall_o.
// TESTING
//  1 add: ALU_OP=10, funct 100000, data1=5, data2=7, no hazards -> next edge ALUout_o=12, RegDstAddr_o=Rd.
//  2 forwarding: Rs=3 with EXMEM (RegWrite=1, Rd=3, ALUout=100) and MEMWB (Rd=3, data=200), data1=1;
//    add with 2 -> 102. Then EXMEM RegWrite=0 -> 202. Then Rs=0 with both matching on 0 -> uses data1.
//  3 mul: 6 * -3 -> stall_o high for exactly MUL_CYCLES cycles, bubbles (WB_o=0) during the stall,
//    then ALUout_o=0xFFFFFFEE with WB_o = WB_i.
//  4 CacheStall_i pulsed 3 cycles mid-MUL -> cnt frozen, total stall = MUL_CYCLES+3, product still correct.
//  5 rst_n_i low mid-MUL, asynchronously between edges -> outputs 0 and stall_o 0 immediately.
//    After release, an add executes normally.
//  6 slt: -1 vs 1 -> 1. sw with ALU_OP=00, ALU_Src=1, immd=8, Rt forwarded from MEMWB=0xAB
//    -> ALUout_o = base+8, MemWriteData_o = 0xAB.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op and funct codes, the multiplier FSM
// encoding and forwarding-source selection.
package ex_pkg;

  localparam int DW_DEF = 32;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  typedef enum logic {S_IDLE, S_MUL} mul_state_t;

  typedef enum logic [1:0] {FW_REG, FW_EXMEM, FW_MEMWB} fwd_sel_t;

  // The younger producer (EX/MEM) shadows MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] src,
                                       input logic       exmem_we,
                                       input logic [4:0] exmem_rd,
                                       input logic       memwb_we,
                                       input logic [4:0] memwb_rd);
    fwd_sel_t sel;
    sel = FW_REG;
    if (src != 5'd0) begin
      if (exmem_we && exmem_rd == src)      sel = FW_EXMEM;
      else if (memwb_we && memwb_rd == src) sel = FW_MEMWB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand/control bundle, forwarding sources and registered EX/MEM outputs.
interface ex_stage_if import ex_pkg::*; #(parameter int DW = DW_DEF);
  logic          CacheStall_i;
  logic [1:0]    WB_i, MEM_i;
  logic          ALU_Src_i;
  logic [1:0]    ALU_OP_i;
  logic          Reg_Dst_i;
  logic [DW-1:0] Reg_data1_i, Reg_data2_i, immd_i;
  logic [4:0]    RsAddr_FW_i, RtAddr_FW_i, RtAddr_WB_i, RdAddr_WB_i;
  logic          EXMEM_RegWrite_i;
  logic [4:0]    EXMEM_RdAddr_i;
  logic [DW-1:0] EXMEM_ALUout_i;
  logic          MEMWB_RegWrite_i;
  logic [4:0]    MEMWB_RdAddr_i;
  logic [DW-1:0] MEMWB_Data_i;
  logic [1:0]    WB_o, MEM_o;
  logic [DW-1:0] ALUout_o, MemWriteData_o;
  logic [4:0]    RegDstAddr_o;
  logic          stall_o;

  modport slave (
    input  CacheStall_i, WB_i, MEM_i, ALU_Src_i, ALU_OP_i, Reg_Dst_i,
           Reg_data1_i, Reg_data2_i, immd_i, RsAddr_FW_i, RtAddr_FW_i,
           RtAddr_WB_i, RdAddr_WB_i, EXMEM_RegWrite_i, EXMEM_RdAddr_i,
           EXMEM_ALUout_i, MEMWB_RegWrite_i, MEMWB_RdAddr_i, MEMWB_Data_i,
    output WB_o, MEM_o, ALUout_o, MemWriteData_o, RegDstAddr_o, stall_o
  );

  modport master (
    output CacheStall_i, WB_i, MEM_i, ALU_Src_i, ALU_OP_i, Reg_Dst_i,
           Reg_data1_i, Reg_data2_i, immd_i, RsAddr_FW_i, RtAddr_FW_i,
           RtAddr_WB_i, RdAddr_WB_i, EXMEM_RegWrite_i, EXMEM_RdAddr_i,
           EXMEM_ALUout_i, MEMWB_RegWrite_i, MEMWB_RdAddr_i, MEMWB_Data_i,
    input  WB_o, MEM_o, ALUout_o, MemWriteData_o, RegDstAddr_o, stall_o
  );
endinterface

// File: rtl/ex_stage_seq_mul.sv
// Iterative shift-add multiplier: operands latched on start, one step per edge, MUL_CYCLES steps.
// hold_i freezes every register; product_o is valid combinationally while last_o is high.
module seq_mul import ex_pkg::*; #(
  parameter int DW         = DW_DEF,
  parameter int MUL_CYCLES = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          hold_i,
  input  logic          start_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          busy_o,
  output logic          last_o,
  output logic [DW-1:0] product_o
);
  localparam int CW = $clog2(MUL_CYCLES);

  mul_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] a_q, b_q, acc_q, acc_step;

  assign acc_step  = acc_q + (b_q[0] ? a_q : '0);
  assign busy_o    = (state_q == S_MUL);
  assign last_o    = busy_o && (cnt_q == CW'(MUL_CYCLES - 1));
  assign product_o = acc_step;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_MUL;
      S_MUL:   if (last_o)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)     state_q <= S_IDLE;
    else if (!hold_i) state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (!hold_i) begin
      if (state_q == S_IDLE && start_i) begin
        a_q   <= a_i;
        b_q   <= b_i;
        acc_q <= '0;
        cnt_q <= '0;
      end else if (state_q == S_MUL) begin
        acc_q <= acc_step;
        a_q   <= a_q << 1;
        b_q   <= b_q >> 1;
        cnt_q <= last_o ? '0 : cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, iterative MUL; results registered one edge after issue.
// stall_o holds ID/EX for the whole MUL; CacheStall_i freezes every register in this stage.
module ex_stage import ex_pkg::*; #(
  parameter int DW         = DW_DEF,
  parameter int MUL_CYCLES = 32
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  ex_stage_if.slave bus
);
  logic [DW-1:0] opa, fwd_b, opb, alu_res, product;
  logic [DW-1:0] alu_q, mwd_q;
  logic [1:0]    wb_q, mem_q;
  logic [4:0]    dst_q, dst_sel;
  logic [5:0]    funct;
  logic          is_mul, mul_busy, mul_last;
  fwd_sel_t      sel_a, sel_b;

  assign sel_a = fwd_sel(bus.RsAddr_FW_i, bus.EXMEM_RegWrite_i, bus.EXMEM_RdAddr_i,
                         bus.MEMWB_RegWrite_i, bus.MEMWB_RdAddr_i);
  assign sel_b = fwd_sel(bus.RtAddr_FW_i, bus.EXMEM_RegWrite_i, bus.EXMEM_RdAddr_i,
                         bus.MEMWB_RegWrite_i, bus.MEMWB_RdAddr_i);

  assign opa   = (sel_a == FW_EXMEM) ? bus.EXMEM_ALUout_i :
                 (sel_a == FW_MEMWB) ? bus.MEMWB_Data_i   : bus.Reg_data1_i;
  assign fwd_b = (sel_b == FW_EXMEM) ? bus.EXMEM_ALUout_i :
                 (sel_b == FW_MEMWB) ? bus.MEMWB_Data_i   : bus.Reg_data2_i;
  assign opb     = bus.ALU_Src_i ? bus.immd_i : fwd_b;
  assign funct   = bus.immd_i[5:0];
  assign is_mul  = (bus.ALU_OP_i == ALUOP_RTYPE) && (funct == FN_MUL);
  assign dst_sel = bus.Reg_Dst_i ? bus.RdAddr_WB_i : bus.RtAddr_WB_i;

  always_comb begin
    alu_res = '0;
    case (bus.ALU_OP_i)
      ALUOP_ADD: alu_res = opa + opb;
      ALUOP_SUB: alu_res = opa - opb;
      ALUOP_ORI: alu_res = opa | opb;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_res = opa + opb;
          FN_SUB:  alu_res = opa - opb;
          FN_AND:  alu_res = opa & opb;
          FN_OR:   alu_res = opa | opb;
          FN_SLT:  alu_res = DW'($signed(opa) < $signed(opb));
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  seq_mul #(.DW(DW), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .hold_i    (bus.CacheStall_i),
    .start_i   (is_mul && !mul_busy),
    .a_i       (opa),
    .b_i       (opb),
    .busy_o    (mul_busy),
    .last_o    (mul_last),
    .product_o (product)
  );

  // Gated by reset so a MUL still sitting in ID/EX cannot assert stall while the stage is held in reset.
  assign bus.stall_o = rst_n_i && ((is_mul && !mul_busy) || (mul_busy && !mul_last));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alu_q <= '0;
      mwd_q <= '0;
      wb_q  <= '0;
      mem_q <= '0;
      dst_q <= '0;
    end else if (!bus.CacheStall_i) begin
      if (mul_busy) begin
        if (mul_last) begin
          alu_q <= product;
          mwd_q <= fwd_b;
          wb_q  <= bus.WB_i;
          mem_q <= bus.MEM_i;
          dst_q <= dst_sel;
        end
      end else if (is_mul) begin
        wb_q  <= '0;
        mem_q <= '0;
      end else begin
        alu_q <= alu_res;
        mwd_q <= fwd_b;
        wb_q  <= bus.WB_i;
        mem_q <= bus.MEM_i;
        dst_q <= dst_sel;
      end
    end
  end

  assign bus.ALUout_o       = alu_q;
  assign bus.MemWriteData_o = mwd_q;
  assign bus.WB_o           = wb_q;
  assign bus.MEM_o          = mem_q;
  assign bus.RegDstAddr_o   = dst_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding priority, MUL stall timing, cache freeze, async reset.
module tb_ex_stage;
  localparam int DW = 32;
  localparam int MC = 32;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  int   errors = 0;
  int   checks = 0;

  ex_stage_if #(.DW(DW)) bus ();

  ex_stage #(.DW(DW), .MUL_CYCLES(MC)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_inputs;
    bus.CacheStall_i = 0; bus.WB_i = 0; bus.MEM_i = 0; bus.ALU_Src_i = 0;
    bus.ALU_OP_i = 0; bus.Reg_Dst_i = 0; bus.Reg_data1_i = 0; bus.Reg_data2_i = 0;
    bus.immd_i = 0; bus.RsAddr_FW_i = 0; bus.RtAddr_FW_i = 0; bus.RtAddr_WB_i = 0;
    bus.RdAddr_WB_i = 0; bus.EXMEM_RegWrite_i = 0; bus.EXMEM_RdAddr_i = 0;
    bus.EXMEM_ALUout_i = 0; bus.MEMWB_RegWrite_i = 0; bus.MEMWB_RdAddr_i = 0;
    bus.MEMWB_Data_i = 0;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_mul(input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    bus.ALU_OP_i = 2'b10; bus.immd_i = 32'h18; bus.Reg_data1_i = a; bus.Reg_data2_i = b;
    bus.RsAddr_FW_i = 5'd1; bus.RtAddr_FW_i = 5'd2; bus.Reg_Dst_i = 1;
    bus.RdAddr_WB_i = 5'd7; bus.WB_i = 2'b11; bus.MEM_i = 2'b01;
  endtask

  task automatic test_reset;
    clear_inputs();
    #3;
    checks++; if (bus.ALUout_o !== 32'd0) begin errors++; $display("FAIL reset_alu got=%h exp=0", bus.ALUout_o); end
    checks++; if (bus.WB_o !== 2'b00) begin errors++; $display("FAIL reset_wb got=%b exp=00", bus.WB_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.stall_o); end
    @(negedge clk_i); rst_n_i = 1;
    tick();
  endtask

  task automatic test_add;
    clear_inputs();
    bus.ALU_OP_i = 2'b10; bus.immd_i = 32'h20; bus.Reg_data1_i = 5; bus.Reg_data2_i = 7;
    bus.RsAddr_FW_i = 5'd1; bus.RtAddr_FW_i = 5'd2; bus.Reg_Dst_i = 1;
    bus.RdAddr_WB_i = 5'd9; bus.RtAddr_WB_i = 5'd4; bus.WB_i = 2'b10;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL add_stall got=%b exp=0", bus.stall_o); end
    tick();
    checks++; if (bus.ALUout_o !== 32'd12) begin errors++; $display("FAIL add_result got=%0d exp=12", bus.ALUout_o); end
    checks++; if (bus.RegDstAddr_o !== 5'd9) begin errors++; $display("FAIL add_dst got=%0d exp=9", bus.RegDstAddr_o); end
    checks++; if (bus.WB_o !== 2'b10) begin errors++; $display("FAIL add_wb got=%b exp=10", bus.WB_o); end
  endtask

  task automatic test_forwarding;
    clear_inputs();
    bus.ALU_OP_i = 2'b10; bus.immd_i = 32'h20; bus.Reg_data1_i = 1; bus.Reg_data2_i = 2;
    bus.RsAddr_FW_i = 5'd3; bus.RtAddr_FW_i = 5'd5;
    bus.EXMEM_RegWrite_i = 1; bus.EXMEM_RdAddr_i = 5'd3; bus.EXMEM_ALUout_i = 100;
    bus.MEMWB_RegWrite_i = 1; bus.MEMWB_RdAddr_i = 5'd3; bus.MEMWB_Data_i = 200;
    tick();
    checks++; if (bus.ALUout_o !== 32'd102) begin errors++; $display("FAIL fwd_exmem got=%0d exp=102", bus.ALUout_o); end
    bus.EXMEM_RegWrite_i = 0;
    tick();
    checks++; if (bus.ALUout_o !== 32'd202) begin errors++; $display("FAIL fwd_memwb got=%0d exp=202", bus.ALUout_o); end
    bus.RsAddr_FW_i = 5'd0; bus.EXMEM_RegWrite_i = 1; bus.EXMEM_RdAddr_i = 5'd0; bus.MEMWB_RdAddr_i = 5'd0;
    tick();
    checks++; if (bus.ALUout_o !== 32'd3) begin errors++; $display("FAIL fwd_reg0 got=%0d exp=3", bus.ALUout_o); end
    bus.RsAddr_FW_i = 5'd8; bus.RtAddr_FW_i = 5'd9; bus.Reg_data1_i = 40;
    bus.EXMEM_RdAddr_i = 5'd9; bus.EXMEM_ALUout_i = 11; bus.MEMWB_RdAddr_i = 5'd8; bus.MEMWB_Data_i = 50;
    tick();
    checks++; if (bus.ALUout_o !== 32'd61) begin errors++; $display("FAIL fwd_split got=%0d exp=61", bus.ALUout_o); end
    checks++; if (bus.MemWriteData_o !== 32'd11) begin errors++; $display("FAIL fwd_mwd got=%0d exp=11", bus.MemWriteData_o); end
  endtask

  task automatic test_mul;
    int n;
    int bad;
    n = 0; bad = 0;
    set_mul(32'd6, 32'hFFFFFFFD);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!bus.stall_o) break;
      n++;
      if (n > 1 && (bus.WB_o !== 2'b00 || bus.MEM_o !== 2'b00)) bad++;
      // Forwarding changes after issue must not reach the latched operands.
      if (n == 4) begin bus.EXMEM_RegWrite_i = 1; bus.EXMEM_RdAddr_i = 5'd1; bus.EXMEM_ALUout_i = 999; end
    end
    if (bus.WB_o !== 2'b00) bad++;
    tick();
    checks++; if (n !== MC) begin errors++; $display("FAIL mul_stall_cycles got=%0d exp=%0d", n, MC); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mul_bubble got=%0d bad cycles exp=0", bad); end
    checks++; if (bus.ALUout_o !== 32'hFFFFFFEE) begin errors++; $display("FAIL mul_product got=%h exp=ffffffee", bus.ALUout_o); end
    checks++; if (bus.WB_o !== 2'b11 || bus.MEM_o !== 2'b01) begin errors++; $display("FAIL mul_ctrl got=%b/%b exp=11/01", bus.WB_o, bus.MEM_o); end
    checks++; if (bus.RegDstAddr_o !== 5'd7) begin errors++; $display("FAIL mul_dst got=%0d exp=7", bus.RegDstAddr_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_cache_stall;
    int n;
    n = 0;
    set_mul(32'd7, 32'd9);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      bus.CacheStall_i = (i >= 5 && i < 8);
      if (!bus.stall_o) break;
      n++;
    end
    tick();
    checks++; if (n !== MC + 3) begin errors++; $display("FAIL cs_stall_cycles got=%0d exp=%0d", n, MC + 3); end
    checks++; if (bus.ALUout_o !== 32'd63) begin errors++; $display("FAIL cs_product got=%0d exp=63", bus.ALUout_o); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_mul;
    set_mul(32'd3, 32'd3);
    repeat (5) @(posedge clk_i);
    #4;
    rst_n_i = 0;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got=%b exp=0", bus.stall_o); end
    checks++; if (bus.ALUout_o !== 32'd0 || bus.MemWriteData_o !== 32'd0) begin errors++; $display("FAIL rst_mid_out got=%h/%h exp=0/0", bus.ALUout_o, bus.MemWriteData_o); end
    @(negedge clk_i);
    rst_n_i = 1;
    clear_inputs();
    bus.ALU_OP_i = 2'b00; bus.Reg_data1_i = 10; bus.Reg_data2_i = 20; bus.WB_i = 2'b10;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_after_stall got=%b exp=0", bus.stall_o); end
    tick();
    checks++; if (bus.ALUout_o !== 32'd30 || bus.WB_o !== 2'b10) begin errors++; $display("FAIL rst_after_add got=%0d/%b exp=30/10", bus.ALUout_o, bus.WB_o); end
  endtask

  task automatic test_slt_sw;
    clear_inputs();
    bus.ALU_OP_i = 2'b10; bus.immd_i = 32'h2A; bus.Reg_data1_i = 32'hFFFFFFFF; bus.Reg_data2_i = 1;
    tick();
    checks++; if (bus.ALUout_o !== 32'd1) begin errors++; $display("FAIL slt_neg got=%0d exp=1", bus.ALUout_o); end
    bus.Reg_data1_i = 1; bus.Reg_data2_i = 32'hFFFFFFFF;
    tick();
    checks++; if (bus.ALUout_o !== 32'd0) begin errors++; $display("FAIL slt_pos got=%0d exp=0", bus.ALUout_o); end
    clear_inputs();
    bus.ALU_OP_i = 2'b00; bus.ALU_Src_i = 1; bus.immd_i = 8; bus.Reg_data1_i = 32'h1000;
    bus.Reg_data2_i = 32'h55; bus.RsAddr_FW_i = 5'd4; bus.RtAddr_FW_i = 5'd6; bus.RtAddr_WB_i = 5'd6;
    bus.MEMWB_RegWrite_i = 1; bus.MEMWB_RdAddr_i = 5'd6; bus.MEMWB_Data_i = 32'hAB; bus.MEM_i = 2'b01;
    tick();
    checks++; if (bus.ALUout_o !== 32'h1008) begin errors++; $display("FAIL sw_addr got=%h exp=1008", bus.ALUout_o); end
    checks++; if (bus.MemWriteData_o !== 32'hAB) begin errors++; $display("FAIL sw_data got=%h exp=ab", bus.MemWriteData_o); end
    checks++; if (bus.RegDstAddr_o !== 5'd6 || bus.MEM_o !== 2'b01) begin errors++; $display("FAIL sw_ctrl got=%0d/%b exp=6/01", bus.RegDstAddr_o, bus.MEM_o); end
  endtask

  task automatic test_back_to_back;
    clear_inputs();
    bus.ALU_OP_i = 2'b01; bus.Reg_data1_i = 10; bus.Reg_data2_i = 3;
    tick();
    checks++; if (bus.ALUout_o !== 32'd7) begin errors++; $display("FAIL b2b_sub got=%0d exp=7", bus.ALUout_o); end
    bus.ALU_OP_i = 2'b10; bus.immd_i = 32'h24; bus.Reg_data1_i = 32'hC; bus.Reg_data2_i = 32'hA;
    tick();
    checks++; if (bus.ALUout_o !== 32'd8) begin errors++; $display("FAIL b2b_and got=%0d exp=8", bus.ALUout_o); end
    bus.immd_i = 32'h3F;
    tick();
    checks++; if (bus.ALUout_o !== 32'd0) begin errors++; $display("FAIL b2b_unknown got=%0d exp=0", bus.ALUout_o); end
    bus.ALU_OP_i = 2'b11; bus.ALU_Src_i = 1; bus.immd_i = 32'hF0; bus.Reg_data1_i = 32'h0F;
    tick();
    checks++; if (bus.ALUout_o !== 32'hFF) begin errors++; $display("FAIL b2b_ori got=%h exp=ff", bus.ALUout_o); end
    bus.ALU_OP_i = 2'b00; bus.ALU_Src_i = 0; bus.Reg_data1_i = 32'hFFFFFFFF; bus.Reg_data2_i = 2;
    tick();
    checks++; if (bus.ALUout_o !== 32'd1) begin errors++; $display("FAIL b2b_wrap got=%0d exp=1", bus.ALUout_o); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_mul();
    test_cache_stall();
    test_reset_mid_mul();
    test_slt_sw();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
